// File: rtl/contar_negro_datapath.sv
// Scan datapath for the CONTAR_NEGRO controller: walks frame-memory addresses one read at a time,
// counting scanned pixels (cont_cursor) and black pixels (black_count, saturating).
module contar_negro_datapath #(
  parameter int unsigned         ADDR_W    = 11,
  parameter int unsigned         PIX_W     = 3,
  parameter int unsigned         CNT_W     = 12,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = {ADDR_W{1'b0}},
  parameter logic [PIX_W-1:0]    BLACK     = {PIX_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_rst,
  input  logic              plus,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_data,
  input  logic              mem_valid,
  output logic [23:0]       cont_cursor,
  output logic [CNT_W-1:0]  black_count,
  output logic              pix_black,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_q;
  logic [23:0]       cont_cursor_q;
  logic [CNT_W-1:0]  black_count_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              pix_black_q;
  logic              busy_q;

  logic [23:0]       cursor_inc_d;
  logic [CNT_W-1:0]  black_inc_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              is_black_d;

  assign cursor_inc_d = cont_cursor_q + 24'd1;
  assign black_inc_d  = (black_count_q == {CNT_W{1'b1}}) ? black_count_q
                      : black_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  // Address wraps modulo 2^ADDR_W because only the low cursor bits are used.
  assign rd_addr_d    = BASE_ADDR + cont_cursor_q[ADDR_W-1:0];
  assign is_black_d   = (mem_data == BLACK);

  // Scan FSM with all outputs registered; mem_rd rises the cycle after REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cont_cursor_q <= 24'd0;
      black_count_q <= {CNT_W{1'b0}};
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= BASE_ADDR;
      pix_black_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      mem_rd_q      <= 1'b0;
      pix_black_q   <= 1'b0;
      cont_cursor_q <= cont_cursor_q;
      black_count_q <= black_count_q;
      case (state_q)
        S_IDLE: begin
          if (out_rst) begin
            cont_cursor_q <= 24'd0;
            black_count_q <= {CNT_W{1'b0}};
            busy_q        <= 1'b0;
          end else if (plus) begin
            state_q <= S_REQ;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_REQ: begin
          // The read goes out even when cleared here, so DRAIN must absorb its response.
          mem_rd_q   <= 1'b1;
          mem_addr_q <= rd_addr_d;
          busy_q     <= 1'b1;
          if (out_rst) begin
            cont_cursor_q <= 24'd0;
            black_count_q <= {CNT_W{1'b0}};
            state_q       <= S_DRAIN;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (out_rst) begin
            cont_cursor_q <= 24'd0;
            black_count_q <= {CNT_W{1'b0}};
            if (mem_valid) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (mem_valid) begin
            cont_cursor_q <= cursor_inc_d;
            if (is_black_d) begin
              black_count_q <= black_inc_d;
              pix_black_q   <= 1'b1;
            end
            if (plus) begin
              state_q <= S_REQ;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          cont_cursor_q <= 24'd0;
          black_count_q <= {CNT_W{1'b0}};
          if (mem_valid) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign cont_cursor = cont_cursor_q;
  assign black_count = black_count_q;
  assign pix_black   = pix_black_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_contar_negro_datapath.sv
// Directed bench for contar_negro_datapath: a latency-programmable memory model, a table of scan
// runs, and hand-written sequences for clear/drain, plus drop, wrap and async reset.
module tb_contar_negro_datapath;

  logic        clk = 1'b0;
  logic        rst, out_rst, plus, mem_valid;
  logic [2:0]  mem_data;
  logic        mem_rd, pix_black, busy;
  logic [10:0] mem_addr;
  logic [23:0] cont_cursor;
  logic [11:0] black_count;
  logic        mem_rd2, pix_black2, busy2;
  logic [10:0] mem_addr2;
  logic [23:0] cont_cursor2;
  logic [1:0]  black_count2;

  contar_negro_datapath dut (
    .clk(clk), .rst(rst), .out_rst(out_rst), .plus(plus),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
    .cont_cursor(cont_cursor), .black_count(black_count), .pix_black(pix_black), .busy(busy)
  );

  contar_negro_datapath #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .out_rst(out_rst), .plus(plus),
    .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_data(mem_data), .mem_valid(mem_valid),
    .cont_cursor(cont_cursor2), .black_count(black_count2), .pix_black(pix_black2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 1;
  int          mcnt     = 0;
  logic [10:0] maddr    = 11'd0;
  logic [2:0]  pix [0:2047];
  logic [2:0]  pat [0:15];

  typedef struct {
    int lat;
    int npix;
    bit all_black;
    int exp_cursor;
    int exp_black;
    int exp_sat;
    int exp_gap;
  } vec_t;

  vec_t vecs [0:3];

  // Memory model: one response, lat cycles after the cycle in which mem_rd is high.
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (mcnt > 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) begin
        mem_valid = 1'b1;
        mem_data  = pix[maddr];
      end
    end
    if (mem_rd) begin
      mcnt  = lat;
      maddr = mem_addr;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_rd(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (mem_rd) ok = 1'b1;
    end
    check({nm, "_rd_seen"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    check({nm, "_idle_seen"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic clear_counters(input string nm);
    @(negedge clk);
    out_rst = 1'b1;
    @(negedge clk);
    out_rst = 1'b0;
    check({nm, "_clr_cursor"}, cont_cursor, 32'd0);
    check({nm, "_clr_black"}, black_count, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    int    n, last, blk, extra;
    bit    done;
    nm = $sformatf("vec%0d", idx);
    for (int i = 0; i < 16; i++) pix[i] = v.all_black ? 3'b000 : pat[i];
    lat = v.lat;
    clear_counters(nm);
    plus = 1'b1;
    n = 0; last = 0; blk = 0; done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (pix_black) blk++;
      if (mem_rd) begin
        check($sformatf("%s_addr%0d", nm, n), {21'd0, mem_addr}, n);
        if (n > 0) check($sformatf("%s_gap%0d", nm, n), cyc - last, v.exp_gap);
        last = cyc;
        n++;
        if (n == v.npix) plus = 1'b0;
      end
      if (n == v.npix && !busy) done = 1'b1;
    end
    check({nm, "_finished"}, {31'd0, done}, 32'd1);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_rd) extra++;
    end
    check({nm, "_reads"}, n, v.npix);
    check({nm, "_extra_reads"}, extra, 32'd0);
    check({nm, "_cursor"}, cont_cursor, v.exp_cursor);
    check({nm, "_black"}, black_count, v.exp_black);
    check({nm, "_pix_black_pulses"}, blk, v.exp_black);
    check({nm, "_black_sat"}, {30'd0, black_count2}, v.exp_sat);
    check({nm, "_cursor2"}, cont_cursor2, v.exp_cursor);
  endtask

  initial begin
    int extra;
    for (int i = 0; i < 2048; i++) pix[i] = 3'b000;
    pat = '{3'd0, 3'd5, 3'd0, 3'd0, 3'd7, 3'd0, 3'd3, 3'd0,
            3'd0, 3'd1, 3'd0, 3'd6, 3'd2, 3'd0, 3'd4, 3'd0};
    vecs[0] = '{lat: 1, npix: 12, all_black: 1'b0, exp_cursor: 12, exp_black: 7, exp_sat: 3, exp_gap: 3};
    vecs[1] = '{lat: 3, npix: 12, all_black: 1'b0, exp_cursor: 12, exp_black: 7, exp_sat: 3, exp_gap: 5};
    vecs[2] = '{lat: 2, npix: 4,  all_black: 1'b0, exp_cursor: 4,  exp_black: 3, exp_sat: 3, exp_gap: 4};
    vecs[3] = '{lat: 1, npix: 5,  all_black: 1'b1, exp_cursor: 5,  exp_black: 5, exp_sat: 3, exp_gap: 3};

    rst = 1'b0; out_rst = 1'b0; plus = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cursor", cont_cursor, 32'd0);
    check("rst_black", black_count, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_addr", {21'd0, mem_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pix_black", {31'd0, pix_black}, 32'd0);
    rst = 1'b1;

    for (int k = 0; k < 4; k++) run_vec(vecs[k], k);

    // out_rst in WAIT, orphan response (black) lands two cycles later in DRAIN.
    lat = 3;
    plus = 1'b1;
    wait_rd("drain");
    plus = 1'b0;
    check("drain_addr", {21'd0, mem_addr}, 32'd5);
    @(negedge clk);
    out_rst = 1'b1;
    @(negedge clk);
    out_rst = 1'b0;
    check("drain_cursor_cleared", cont_cursor, 32'd0);
    check("drain_black_cleared", black_count, 32'd0);
    check("drain_busy_held", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("drain_busy_before_resp", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("drain_busy_after_resp", {31'd0, busy}, 32'd0);
    check("drain_cursor_final", cont_cursor, 32'd0);
    check("drain_black_final", black_count, 32'd0);
    check("drain_black2_final", {30'd0, black_count2}, 32'd0);
    check("drain_pix_black", {31'd0, pix_black}, 32'd0);

    // out_rst coinciding with mem_valid: response discarded, straight to IDLE.
    lat = 1;
    plus = 1'b1;
    wait_rd("clrvalid");
    plus = 1'b0;
    @(negedge clk);
    out_rst = 1'b1;
    @(negedge clk);
    out_rst = 1'b0;
    check("clrvalid_busy", {31'd0, busy}, 32'd0);
    check("clrvalid_cursor", cont_cursor, 32'd0);
    check("clrvalid_black", black_count, 32'd0);
    check("clrvalid_pix_black", {31'd0, pix_black}, 32'd0);

    // plus dropped the cycle after mem_rd: pending pixel still counted, no further reads.
    lat = 3;
    plus = 1'b1;
    wait_rd("plusdrop");
    @(negedge clk);
    plus = 1'b0;
    wait_idle("plusdrop");
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_rd) extra++;
    end
    check("plusdrop_cursor", cont_cursor, 32'd1);
    check("plusdrop_black", black_count, 32'd1);
    check("plusdrop_extra_reads", extra, 32'd0);

    // Cursor wrap at 2^24 and address wrap at 2^ADDR_W.
    clear_counters("wrap");
    @(negedge clk);
    force dut.cont_cursor_q = 24'hFFFFFF;
    force dut2.cont_cursor_q = 24'hFFFFFF;
    @(negedge clk);
    release dut.cont_cursor_q;
    release dut2.cont_cursor_q;
    @(negedge clk);
    check("wrap_preload", cont_cursor, 32'h00FFFFFF);
    lat = 1;
    plus = 1'b1;
    wait_rd("wrap1");
    plus = 1'b0;
    check("wrap_addr_top", {21'd0, mem_addr}, 32'h7FF);
    wait_idle("wrap1");
    check("wrap_cursor_zero", cont_cursor, 32'd0);
    check("wrap_black1", black_count, 32'd1);
    plus = 1'b1;
    wait_rd("wrap2");
    plus = 1'b0;
    check("wrap_addr_zero", {21'd0, mem_addr}, 32'd0);
    wait_idle("wrap2");
    check("wrap_cursor_one", cont_cursor, 32'd1);
    check("wrap_black2", black_count, 32'd2);

    // Async reset between edges while WAIT; the late response must be ignored.
    lat = 3;
    plus = 1'b1;
    wait_rd("arst");
    plus = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_cursor", cont_cursor, 32'd0);
    check("arst_black", black_count, 32'd0);
    check("arst_black2", {30'd0, black_count2}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("arst_addr", {21'd0, mem_addr}, 32'd0);
    check("arst_pix_black", {31'd0, pix_black}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_late_cursor", cont_cursor, 32'd0);
    check("arst_late_black", black_count, 32'd0);
    check("arst_late_busy", {31'd0, busy}, 32'd0);
    check("arst_late_mem_rd", {31'd0, mem_rd}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
